// File: rtl/rtc_timer_v2_if.sv
// Control/status bundle between the key debouncers, the RTC core and the digit renderers.
// The master drives controls and presets; the slave (the RTC core) returns counts and display digits.
interface rtc_timer_v2_if;
   logic       clr;
   logic       enable;
   logic       dir;
   logic       load;
   logic [4:0] preset_hour;
   logic [5:0] preset_min;
   logic [5:0] preset_sec;
   logic       inc_min;
   logic       dec_min;
   logic       inc_hour;
   logic       dec_hour;
   logic       alarm_en;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       hour12;
   logic [9:0] ms;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [7:0] bcd_hh;
   logic [7:0] bcd_mm;
   logic [7:0] bcd_ss;
   logic       pm;
   logic       alarm;
   logic       done;

   modport master (
      output clr, enable, dir, load, preset_hour, preset_min, preset_sec,
             inc_min, dec_min, inc_hour, dec_hour, alarm_en, alarm_hour, alarm_min, hour12,
      input  ms, sec, min, hour, bcd_hh, bcd_mm, bcd_ss, pm, alarm, done
   );

   modport slave (
      input  clr, enable, dir, load, preset_hour, preset_min, preset_sec,
             inc_min, dec_min, inc_hour, dec_hour, alarm_en, alarm_hour, alarm_min, hour12,
      output ms, sec, min, hour, bcd_hh, bcd_mm, bcd_ss, pm, alarm, done
   );
endinterface

// File: rtl/rtc_timer_v2.sv
// Time-of-day / stopwatch / countdown counter with internal ms prescaler, manual adjust,
// one-shot alarm and registered 12/24-hour BCD display digits.
module rtc_timer_v2 #(
   parameter int unsigned CLK_DIV  = 50000,
   parameter int unsigned HOUR_MOD = 24
) (
   input  logic          clk,
   input  logic          rst_N,
   rtc_timer_v2_if.slave bus
);
   localparam int unsigned PW  = $clog2(CLK_DIV);
   localparam int unsigned MSW = 10;
   localparam int unsigned SW  = 6;
   localparam int unsigned HW  = 5;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HOUR_LAST  = HW'(HOUR_MOD - 1);

   logic [PW-1:0]  presc_q, presc_d;
   logic [MSW-1:0] ms_q, ms_d;
   logic [SW-1:0]  sec_q, sec_d;
   logic [SW-1:0]  min_q, min_d;
   logic [HW-1:0]  hour_q, hour_d;
   logic           done_q, done_d;
   logic           alarm_q, alarm_d;
   logic [7:0]     bcd_hh_q, bcd_hh_d;
   logic [7:0]     bcd_mm_q, bcd_mm_d;
   logic [7:0]     bcd_ss_q, bcd_ss_d;
   logic           pm_q, pm_d;

   logic           tick;
   logic           adj_any;
   logic           at_zero;
   logic           stepped;
   logic [HW-1:0]  hour_adj;
   logic [HW-1:0]  disp_hour;

   function automatic logic [HW-1:0] hour_plus(input logic [HW-1:0] h);
      return (h == HOUR_LAST) ? '0 : h + HW'(1);
   endfunction

   function automatic logic [HW-1:0] hour_minus(input logic [HW-1:0] h);
      return (h == '0) ? HOUR_LAST : h - HW'(1);
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [5:0] tens;
      tens = v / 6'd10;
      return {tens[3:0], 4'(v - tens * 6'd10)};
   endfunction

   // Count, prescaler, done and alarm next-state (priority clr > load > adjust > tick)
   always_comb begin
      presc_d  = presc_q;
      ms_d     = ms_q;
      sec_d    = sec_q;
      min_d    = min_q;
      hour_d   = hour_q;
      done_d   = done_q;
      alarm_d  = 1'b0;
      stepped  = 1'b0;
      hour_adj = hour_q;
      tick     = bus.enable && (presc_q == PRESC_LAST);
      adj_any  = bus.inc_min | bus.dec_min | bus.inc_hour | bus.dec_hour;
      at_zero  = (ms_q == '0) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);

      if (bus.enable) presc_d = tick ? '0 : presc_q + PW'(1);

      if (bus.clr) begin
         presc_d = '0;
         ms_d    = '0;
         sec_d   = '0;
         min_d   = '0;
         hour_d  = '0;
         done_d  = 1'b0;
      end else if (bus.load) begin
         presc_d = '0;
         ms_d    = '0;
         sec_d   = (bus.preset_sec  > 6'd59)    ? 6'd59     : bus.preset_sec;
         min_d   = (bus.preset_min  > 6'd59)    ? 6'd59     : bus.preset_min;
         hour_d  = (bus.preset_hour > HOUR_LAST) ? HOUR_LAST : bus.preset_hour;
         done_d  = 1'b0;
      end else if (adj_any) begin
         // Minute carry/borrow first, hour adjust stacked on top; tick is dropped
         if (bus.inc_min && !bus.dec_min) begin
            if (min_q == 6'd59) begin
               min_d    = '0;
               hour_adj = hour_plus(hour_q);
            end else begin
               min_d = min_q + SW'(1);
            end
         end else if (bus.dec_min && !bus.inc_min) begin
            if (min_q == '0) begin
               min_d    = 6'd59;
               hour_adj = hour_minus(hour_q);
            end else begin
               min_d = min_q - SW'(1);
            end
         end
         if (bus.inc_hour && !bus.dec_hour)      hour_d = hour_plus(hour_adj);
         else if (bus.dec_hour && !bus.inc_hour) hour_d = hour_minus(hour_adj);
         else                                    hour_d = hour_adj;
      end else if (tick) begin
         if (!bus.dir) begin
            stepped = 1'b1;
            done_d  = 1'b0;
            if (ms_q == 10'd999) begin
               ms_d = '0;
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == 6'd59) begin
                     min_d  = '0;
                     hour_d = hour_plus(hour_q);
                  end else begin
                     min_d = min_q + SW'(1);
                  end
               end else begin
                  sec_d = sec_q + SW'(1);
               end
            end else begin
               ms_d = ms_q + MSW'(1);
            end
         end else if (at_zero) begin
            done_d = 1'b1;
         end else begin
            stepped = 1'b1;
            if (ms_q == '0) begin
               ms_d = 10'd999;
               if (sec_q == '0) begin
                  sec_d = 6'd59;
                  if (min_q == '0) begin
                     min_d  = 6'd59;
                     hour_d = hour_minus(hour_q);
                  end else begin
                     min_d = min_q - SW'(1);
                  end
               end else begin
                  sec_d = sec_q - SW'(1);
               end
            end else begin
               ms_d = ms_q - MSW'(1);
            end
            done_d = (ms_d == '0) && (sec_d == '0) && (min_d == '0) && (hour_d == '0);
         end
      end

      // Alarm only on a counting step that lands exactly on hh:mm:00.000
      if (stepped && bus.alarm_en && (ms_d == '0) && (sec_d == '0) &&
          (min_d == bus.alarm_min) && (hour_d == bus.alarm_hour)) begin
         alarm_d = 1'b1;
      end
   end

   // Display digits derived from the current count registers
   always_comb begin
      disp_hour = hour_q;
      if (bus.hour12) begin
         if (hour_q == '0)          disp_hour = HW'(12);
         else if (hour_q > HW'(12)) disp_hour = hour_q - HW'(12);
      end
      bcd_hh_d = to_bcd(6'(disp_hour));
      bcd_mm_d = to_bcd(min_q);
      bcd_ss_d = to_bcd(sec_q);
      pm_d     = bus.hour12 && (hour_q >= HW'(12));
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         presc_q  <= '0;
         ms_q     <= '0;
         sec_q    <= '0;
         min_q    <= '0;
         hour_q   <= '0;
         done_q   <= 1'b0;
         alarm_q  <= 1'b0;
         bcd_hh_q <= '0;
         bcd_mm_q <= '0;
         bcd_ss_q <= '0;
         pm_q     <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         ms_q     <= ms_d;
         sec_q    <= sec_d;
         min_q    <= min_d;
         hour_q   <= hour_d;
         done_q   <= done_d;
         alarm_q  <= alarm_d;
         bcd_hh_q <= bcd_hh_d;
         bcd_mm_q <= bcd_mm_d;
         bcd_ss_q <= bcd_ss_d;
         pm_q     <= pm_d;
      end
   end

   assign bus.ms     = ms_q;
   assign bus.sec    = sec_q;
   assign bus.min    = min_q;
   assign bus.hour   = hour_q;
   assign bus.bcd_hh = bcd_hh_q;
   assign bus.bcd_mm = bcd_mm_q;
   assign bus.bcd_ss = bcd_ss_q;
   assign bus.pm     = pm_q;
   assign bus.alarm  = alarm_q;
   assign bus.done   = done_q;
endmodule

// File: doc/rtc_timer_v2.md
Name: rtc_timer_v2

Overview:
Parametrised successor to the display-board time-of-day counter. It keeps the ms/sec/min/hour count with the existing manual minute/hour adjust. New capabilities:
- built-in clock prescaler, so no external 1 kHz enable is needed
- up (clock/stopwatch) or down (countdown) counting, with preset load
- one-shot alarm
- 12/24-hour BCD display
Sits between the key debouncers and the VGA/7-seg digit renderers.

Parameters:
CLK_DIV, 50000, clk cycles per 1 ms tick (>=2); prescaler width = $clog2(CLK_DIV)
HOUR_MOD, 24, hour wrap modulus (2..32); hour counts 0..HOUR_MOD-1

Ports:
clk  in  1  system clock
rst_N  in  1  async active-low reset
clr  in  1  sync clear of count, prescaler, done
enable  in  1  1 = run prescaler/tick; 0 = freeze count (adjust still works)
dir  in  1  0 = count up, 1 = count down
load  in  1  sync pulse: load preset_hour/min/sec, ms := 0
preset_hour/preset_min/preset_sec  in  5/6/6  load values; out-of-range fields are clamped to the max legal value
inc_min, dec_min, inc_hour, dec_hour  in  1  one-cycle adjust pulses
alarm_en  in  1  alarm enable
alarm_hour/alarm_min  in  5/6  alarm time
hour12  in  1  display format: 1 = 12-hour
ms/sec/min/hour  out  10/6/6/5  binary count registers
bcd_hh, bcd_mm, bcd_ss  out  8 each  {tens,units} BCD display digits
pm  out  1  1 when hour>=12 and hour12=1, else 0
alarm  out  1  one-cycle alarm pulse
done  out  1  countdown reached zero (sticky)

Behaviour:
- Reset (rst_N low, async): all counts 0, prescaler 0, all BCD outputs 8'h00, pm=0, alarm=0, done=0.
- Priority per cycle: clr > load > adjust > tick. clr and load both zero the prescaler and clear done.
- Prescaler runs only when enable=1. tick=1 in the cycle the prescaler equals CLK_DIV-1; the prescaler then wraps to 0.
- Up tick: ms 0..999 carries to sec 0..59, then min 0..59, then hour 0..HOUR_MOD-1; full wrap returns to all zero.
- Down tick: borrow chain, the mirror image of the up tick.
  - At 0:00:00.000 with dir=1, count holds, done:=1 and no further decrement occurs.
  - done stays set until clr or load, or until dir=0 and a tick occurs.
- Adjust (pulses valid regardless of enable):
  - inc_min&dec_min both high = no minute action; same rule for the hour pair.
  - inc_min at 59 -> 0 with hour+1 (mod). dec_min at 0 -> 59 with hour-1 (mod).
  - inc_hour/dec_hour wrap mod HOUR_MOD. Minute and hour adjusts in the same cycle: the hour adjust is applied last, on top of any carry.
  - Any adjust pulse suppresses that cycle's tick (the ms is lost); the prescaler keeps running.
- Alarm: alarm=1 for exactly one cycle, the cycle after a tick makes the count equal alarm_hour:alarm_min:00.000 with alarm_en=1. Equality reached by load or adjust never fires. Fires in both directions.
- Display: BCD/pm registered from count registers, latency 1 cycle.
  - hour12=0: bcd_hh = hour.
  - hour12=1: hour 0->12, 1..12 unchanged, 13..23 -> hour-12.
  - bcd_mm = min, bcd_ss = sec.
- No combinational path from any input to any output.

Test Plan:
- CLK_DIV=4: reset, enable=1 for 4000 clk -> sec=1, ms=0, bcd_ss=8'h01 one cycle after the sec change.
- load 23:59:59, enable, 1000 ticks -> all counts 0, bcd_hh=8'h00; with HOUR_MOD=12 the same test from 11:59:59 wraps to 0.
- dir=1, load 0:00:01, 1000 ticks -> 0:00:00.000, done=1; 50 further ticks -> count unchanged; load clears done.
- alarm 07:30, load 07:29:59, run 1000 ticks -> alarm pulses once, width 1 clk. load 07:30:00 directly -> no pulse.
- inc_min at 10:59 -> 11:00; inc_min&dec_min together -> no change; inc_min coincident with tick -> ms unchanged that cycle.
- hour12=1 at hour 0/12/13 -> bcd_hh 8'h12/8'h12/8'h01, pm 0/1/1. Assert rst_N low mid-count -> all outputs 0 immediately.
